// File: rtl/hvac_zone_scheduler.sv
// hvac_zone_scheduler: shares one heating/cooling plant between NZ zones.
// Each zone gets a hysteretic heat/cool demand. A round-robin arbiter grants
// the plant to one zone at a time. Every grant lasts at least DWELL cycles,
// and consecutive grants are separated by DEAD plant-off cycles.
module hvac_zone_scheduler #(
  parameter int NZ       = 4,
  parameter int TW       = 5,
  parameter int HEAT_ON  = 12,
  parameter int HEAT_OFF = 18,
  parameter int COOL_OFF = 20,
  parameter int COOL_ON  = 26,
  parameter int DWELL    = 16,
  parameter int DEAD     = 4,
  localparam int ZW      = $clog2(NZ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NZ*TW-1:0] temp,
  input  logic             temp_valid,
  output logic [NZ-1:0]    demand_heat,
  output logic [NZ-1:0]    demand_cool,
  output logic [1:0]       plant_mode,
  output logic [NZ-1:0]    zone_valve,
  output logic [ZW-1:0]    grant_zone,
  output logic             busy
);

  localparam int DCW = $clog2(DWELL);
  localparam int XCW = $clog2(DEAD + 1);
  localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL - 1);
  localparam logic [XCW-1:0] DEAD_LAST  = XCW'(DEAD - 1);

  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_DEAD} state_t;

  state_t         state;
  logic [ZW-1:0]  last;
  logic [DCW-1:0] dwell_cnt;
  logic [XCW-1:0] dead_cnt;

  logic [NZ-1:0]  heat_next;
  logic [NZ-1:0]  cool_next;
  logic [NZ-1:0]  any_demand;
  logic [NZ-1:0]  others_demand;
  logic           served_active;
  logic           pick_found;
  logic [ZW-1:0]  pick_idx;

  // Per-zone hysteresis: inside the band the previous demand is kept.
  for (genvar gi = 0; gi < NZ; gi++) begin : g_zone
    logic [TW-1:0] t;
    assign t = temp[gi*TW +: TW];
    assign heat_next[gi] = (t <  TW'(HEAT_ON))  ? 1'b1 :
                           (t >= TW'(HEAT_OFF)) ? 1'b0 : demand_heat[gi];
    assign cool_next[gi] = (t >  TW'(COOL_ON))  ? 1'b1 :
                           (t <= TW'(COOL_OFF)) ? 1'b0 : demand_cool[gi];
  end

  // Demand registers only update on a valid temperature sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      demand_heat <= '0;
      demand_cool <= '0;
    end else if (temp_valid) begin
      demand_heat <= heat_next;
      demand_cool <= cool_next;
    end
  end

  assign any_demand    = demand_heat | demand_cool;
  assign others_demand = any_demand & ~(NZ'(1) << grant_zone);
  // The active mode of a grant is held in plant_mode while serving.
  assign served_active = plant_mode[1] ? demand_heat[grant_zone]
                                       : demand_cool[grant_zone];

  // Round-robin search from last+1; smallest offset wins, so scan downwards.
  always_comb begin : arb
    int cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = NZ; k >= 1; k--) begin
      cand = int'(last) + k;
      if (cand >= NZ) cand -= NZ;
      if (any_demand[ZW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = ZW'(cand);
      end
    end
  end

  // Grant FSM with registered plant outputs; reset drops the plant at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      plant_mode <= 2'b00;
      zone_valve <= '0;
      grant_zone <= '0;
      last       <= ZW'(NZ - 1);
      dwell_cnt  <= '0;
      dead_cnt   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            state      <= S_SERVE;
            grant_zone <= pick_idx;
            last       <= pick_idx;
            zone_valve <= NZ'(1) << pick_idx;
            plant_mode <= demand_heat[pick_idx] ? 2'b10 : 2'b01;
            dwell_cnt  <= '0;
            busy       <= 1'b1;
          end
        end
        S_SERVE: begin
          if (dwell_cnt != DWELL_LAST) begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end else if (!served_active || (|others_demand)) begin
            state      <= S_DEAD;
            plant_mode <= 2'b00;
            zone_valve <= '0;
            dead_cnt   <= '0;
          end
        end
        S_DEAD: begin
          if (dead_cnt == DEAD_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            dead_cnt <= dead_cnt + 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          plant_mode <= 2'b00;
          zone_valve <= '0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hvac_zone_scheduler.sv
// Directed bench for hvac_zone_scheduler with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_hvac_zone_scheduler;
  localparam int NZ = 4;
  localparam int TW = 5;
  localparam int ZW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NZ*TW-1:0] temp;
  logic             temp_valid;
  logic [NZ-1:0]    demand_heat;
  logic [NZ-1:0]    demand_cool;
  logic [1:0]       plant_mode;
  logic [NZ-1:0]    zone_valve;
  logic [ZW-1:0]    grant_zone;
  logic             busy;

  int total = 0;
  int bad   = 0;

  hvac_zone_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .temp        (temp),
    .temp_valid  (temp_valid),
    .demand_heat (demand_heat),
    .demand_cool (demand_cool),
    .plant_mode  (plant_mode),
    .zone_valve  (zone_valve),
    .grant_zone  (grant_zone),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic setz(input int z, input int v);
    temp[z*TW +: TW] = v[TW-1:0];
  endtask

  // Neutral temperature 19 clears both demands.
  task automatic do_reset();
    rst = 1'b1;
    temp_valid = 1'b0;
    for (int z = 0; z < NZ; z++) setz(z, 19);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One-cycle sample of zone z at value v; demand visible at the next negedge.
  task automatic sample(input int z, input int v);
    setz(z, v);
    temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
  endtask

  // Waits for a grant, checks its zone/mode, then measures its length.
  task automatic serve(input string tag, input int zone, input logic [1:0] mode, input int exp_off);
    int off;
    int on;
    off = 0;
    on  = 0;
    while (plant_mode == 2'b00 && off < 200) begin
      off++;
      @(negedge clk);
    end
    if (exp_off >= 0) chk({tag, "_off"}, off, exp_off);
    chk({tag, "_zone"}, grant_zone, zone);
    chk({tag, "_valve"}, zone_valve, NZ'(1) << zone);
    chk({tag, "_mode"}, plant_mode, mode);
    while (plant_mode == mode && zone_valve != 0 && on < 200) begin
      on++;
      @(negedge clk);
    end
    chk({tag, "_len"}, on, 16);
    chk({tag, "_offnext"}, plant_mode, 2'b00);
    $display("grant %s zone=%0d mode=%0d off=%0d len=%0d", tag, grant_zone, mode, off, on);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk(tag, busy, 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : main
    int on;
    int dead;
    temp = '0;
    do_reset();

    // Reset state.
    chk("rst_heat", demand_heat, 0);
    chk("rst_cool", demand_cool, 0);
    chk("rst_mode", plant_mode, 0);
    chk("rst_valve", zone_valve, 0);
    chk("rst_grant", grant_zone, 0);
    chk("rst_busy", busy, 0);

    // Single heat request on zone 1, cleared early in SERVE.
    sample(1, 8);
    chk("s1_dem", demand_heat, 4'b0010);
    chk("s1_idle_mode", plant_mode, 0);
    @(negedge clk);
    chk("s1_mode", plant_mode, 2'b10);
    chk("s1_valve", zone_valve, 4'b0010);
    chk("s1_grant", grant_zone, 1);
    chk("s1_busy", busy, 1);
    on = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 2) begin
        setz(1, 19);
        temp_valid = 1'b1;
      end
      if (i == 3) temp_valid = 1'b0;
      if (i == 5) chk("s1_cleared", demand_heat, 0);
      if (plant_mode == 2'b10) on++;
      @(negedge clk);
    end
    chk("s1_len", on, 16);
    dead = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy && plant_mode == 2'b00 && zone_valve == 0) dead++;
      @(negedge clk);
    end
    chk("s1_dead", dead, 4);
    chk("s1_done_busy", busy, 0);
    $display("scenario1 len=%0d dead=%0d", on, dead);

    // Hysteresis on zone 0.
    sample(0, 11); chk("hy_h11", demand_heat[0], 1);
    sample(0, 15); chk("hy_h15", demand_heat[0], 1);
    sample(0, 18); chk("hy_h18", demand_heat[0], 0);
    sample(0, 15); chk("hy_h15b", demand_heat[0], 0);
    sample(0, 27); chk("hy_c27", demand_cool[0], 1);
    chk("hy_excl", demand_heat & demand_cool, 0);
    sample(0, 22); chk("hy_c22", demand_cool[0], 1);
    sample(0, 20); chk("hy_c20", demand_cool[0], 0);
    wait_idle("hy_idle");

    // Round robin over zones 0, 2, 3.
    do_reset();
    setz(0, 5);
    setz(2, 5);
    setz(3, 5);
    temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
    serve("rr0", 0, 2'b10, 1);
    serve("rr2", 2, 2'b10, 5);
    serve("rr3", 3, 2'b10, 5);
    serve("rr0b", 0, 2'b10, 5);

    // Cool then heat with dead time in between.
    do_reset();
    setz(0, 30);
    setz(1, 5);
    temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
    serve("mx0", 0, 2'b01, 1);
    serve("mx1", 1, 2'b10, 5);

    // Lone persistent demand, then reset mid-SERVE.
    do_reset();
    sample(2, 5);
    on = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (plant_mode == 2'b10 && zone_valve == 4'b0100) on++;
    end
    chk("lone_on", on, 40);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_mode", plant_mode, 0);
    chk("mid_valve", zone_valve, 0);
    chk("mid_heat", demand_heat, 0);
    chk("mid_busy", busy, 0);
    setz(0, 5);
    temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
    chk("mid_dem", demand_heat, 4'b0101);
    serve("mid_first", 0, 2'b10, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
